// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the unified memory-port arbiter.
// Pipeline stages import the status codes from here rather than using literals.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    STAT_IDLE = 2'b00,
    STAT_PEND = 2'b01,
    STAT_DONE = 2'b10,
    STAT_ERR  = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP_I,
    ST_RESP_D
  } arb_state_e;

  localparam int DEF_TIMEOUT      = 16;
  localparam int DEF_STARVE_LIMIT = 4;

  // Completion code for a finished transaction.
  function automatic status_e doneStatus(input logic isErr);
    status_e s;
    if (isErr) s = STAT_ERR;
    else       s = STAT_DONE;
    return s;
  endfunction

  // Status shown by a requester that is not currently being served.
  function automatic status_e pendIf(input logic req);
    status_e s;
    if (req) s = STAT_PEND;
    else     s = STAT_IDLE;
    return s;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating cycle counter used to abort memory transactions that never ack.
// o_expired rises once TIMEOUT-1 enabled cycles have been counted since clear.
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // Count enabled cycles, holding at the last value; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
// Data wins ties unless fetch has lost STARVE_LIMIT arbitrations in a row;
// a watchdog converts a missing m_ack into an error completion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [1:0]  i_status,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [1:0]  d_status,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    r_state;
  status_e       r_iStat;
  status_e       r_dStat;
  logic [31:0]   r_iRdata;
  logic [31:0]   r_dRdata;
  logic          r_mReq;
  logic          r_mWe;
  logic [31:0]   r_mAddr;
  logic [31:0]   r_mWdata;
  logic [SW-1:0] r_starveCnt;

  logic w_grantD;
  logic w_grantI;
  logic w_busy;
  logic w_expired;

  assign w_grantD = d_req && (!i_req || (r_starveCnt < STARVE_MAX));
  assign w_grantI = i_req && !w_grantD;
  assign w_busy   = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_busy),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  // Arbitration FSM with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_iStat     <= STAT_IDLE;
      r_dStat     <= STAT_IDLE;
      r_iRdata    <= '0;
      r_dRdata    <= '0;
      r_mReq      <= 1'b0;
      r_mWe       <= 1'b0;
      r_mAddr     <= '0;
      r_mWdata    <= '0;
      r_starveCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_iStat <= pendIf(i_req);
          r_dStat <= pendIf(d_req);
          if (w_grantD) begin
            r_state  <= ST_BUSY_D;
            r_mReq   <= 1'b1;
            r_mAddr  <= d_addr;
            r_mWe    <= d_we;
            r_mWdata <= d_wdata;
            if (i_req && (r_starveCnt != STARVE_MAX)) begin
              r_starveCnt <= r_starveCnt + SW'(1);
            end
          end else if (w_grantI) begin
            r_state     <= ST_BUSY_I;
            r_mReq      <= 1'b1;
            r_mAddr     <= i_addr;
            r_mWe       <= 1'b0;
            r_starveCnt <= '0;
          end
        end

        ST_BUSY_I: begin
          r_iStat <= STAT_PEND;
          r_dStat <= pendIf(d_req);
          if (m_ack) begin
            r_state  <= ST_RESP_I;
            r_mReq   <= 1'b0;
            r_iRdata <= m_rdata;
            r_iStat  <= doneStatus(m_err);
          end else if (w_expired) begin
            r_state <= ST_RESP_I;
            r_mReq  <= 1'b0;
            r_iStat <= STAT_ERR;
          end
        end

        ST_BUSY_D: begin
          r_dStat <= STAT_PEND;
          r_iStat <= pendIf(i_req);
          if (m_ack) begin
            r_state <= ST_RESP_D;
            r_mReq  <= 1'b0;
            if (!r_mWe) begin
              r_dRdata <= m_rdata;
            end
            r_dStat <= doneStatus(m_err);
          end else if (w_expired) begin
            r_state <= ST_RESP_D;
            r_mReq  <= 1'b0;
            r_dStat <= STAT_ERR;
          end
        end

        ST_RESP_I, ST_RESP_D: begin
          r_state <= ST_IDLE;
          r_iStat <= pendIf(i_req);
          r_dStat <= pendIf(d_req);
        end

        default: begin
          r_state <= ST_IDLE;
          r_mReq  <= 1'b0;
          r_iStat <= STAT_IDLE;
          r_dStat <= STAT_IDLE;
        end
      endcase
    end
  end

  assign i_status = r_iStat;
  assign d_status = r_dStat;
  assign i_rdata  = r_iRdata;
  assign d_rdata  = r_dRdata;
  assign m_req    = r_mReq;
  assign m_we     = r_mWe;
  assign m_addr   = r_mAddr;
  assign m_wdata  = r_mWdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table, starvation
// grant-order and mid-transaction reset sequences, then randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TIMEOUT      = 16;
  localparam int STARVE_LIMIT = 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PEND = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [1:0]  i_status;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_status;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isData;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    bit          err;
    logic [1:0]  expStatus;
    logic [31:0] expRdata;
  } vec_t;

  mem_arbiter #(
    .TIMEOUT      (TIMEOUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_status (i_status),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_status (d_status),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .m_err    (m_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case a sequence stalls forever.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive m_ack per the requested delay (delay < 0 means never) and check the
  // winner's status every cycle until the expected completion edge.
  task automatic serveTxn(input bit winD, input int delay, input logic [31:0] rdata,
                          input bit err, input logic [1:0] expDone, input bit loserReq,
                          input string tag);
    int doneAt;
    doneAt = (delay > 0) ? delay : TIMEOUT;
    for (int c = 1; c <= doneAt; c++) begin
      if (c == delay) begin
        m_ack   = 1'b1;
        m_rdata = rdata;
        m_err   = err;
      end else begin
        m_ack   = 1'b0;
        m_rdata = $urandom;
        m_err   = 1'($urandom_range(0, 1));
      end
      tick();
      m_ack = 1'b0;
      m_err = 1'b0;
      if (c == doneAt) begin
        checkOutput({tag, "_done_status"}, winD ? d_status : i_status, expDone);
        checkOutput({tag, "_mreq_low"}, m_req, 0);
      end else begin
        checkOutput({tag, "_pend_status"}, winD ? d_status : i_status, S_PEND);
        checkOutput({tag, "_other_status"}, winD ? i_status : d_status,
                    loserReq ? S_PEND : S_IDLE);
        checkOutput({tag, "_mreq_high"}, m_req, 1);
      end
    end
  endtask

  // Run one single-requester transaction from a table row.
  task automatic applyStimulus(input vec_t v, input int k);
    string tag;
    tag     = $sformatf("row%0d", k);
    i_req   = !v.isData;
    d_req   = v.isData;
    i_addr  = v.addr;
    d_addr  = v.addr;
    d_we    = v.we;
    d_wdata = v.wdata;
    tick();
    checkOutput({tag, "_mreq"}, m_req, 1);
    checkOutput({tag, "_maddr"}, m_addr, v.addr);
    checkOutput({tag, "_mwe"}, m_we, (v.isData && v.we) ? 1 : 0);
    if (v.isData && v.we) checkOutput({tag, "_mwdata"}, m_wdata, v.wdata);
    checkOutput({tag, "_grant_status"}, v.isData ? d_status : i_status, S_PEND);
    serveTxn(v.isData, v.delay, v.rdata, v.err, v.expStatus, 1'b0, tag);
    checkOutput({tag, "_rdata"}, v.isData ? d_rdata : i_rdata, v.expRdata);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    checkOutput({tag, "_after_istat"}, i_status, S_IDLE);
    checkOutput({tag, "_after_dstat"}, d_status, S_IDLE);
  endtask

  initial begin
    vec_t        vecs[7];
    bit          grantD[10];
    int          nGrants;
    int          cyc;
    logic        prevReq;
    int          starve;
    bit          expD;
    logic [31:0] mIR, mDR;
    bit          pendI, pendD, dW, winD, timedOut, er;
    logic [31:0] iA, dA, dWd, rd;
    int          delay;

    // isData, we, addr, wdata, delay, rdata, err, expStatus, expRdata
    vecs[0] = '{0, 1, 32'h0000_1000, 32'h0,         2,  32'h2408_0001, 0, S_DONE, 32'h2408_0001};
    vecs[1] = '{1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 1,  32'h1111_1111, 0, S_DONE, 32'h0000_0000};
    vecs[2] = '{1, 0, 32'h0000_3000, 32'h0,         3,  32'hCAFE_F00D, 1, S_ERR,  32'hCAFE_F00D};
    vecs[3] = '{1, 0, 32'h0000_3004, 32'h0,         1,  32'h1234_5678, 0, S_DONE, 32'h1234_5678};
    vecs[4] = '{0, 0, 32'h0000_1004, 32'h0,         -1, 32'h0,         0, S_ERR,  32'h2408_0001};
    vecs[5] = '{0, 1, 32'h0000_1008, 32'h0,         1,  32'hA5A5_A5A5, 0, S_DONE, 32'hA5A5_A5A5};
    vecs[6] = '{1, 1, 32'h0000_2004, 32'h5555_AAAA, 4,  32'h9999_9999, 1, S_ERR,  32'h1234_5678};

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0; m_rdata = '0; m_err = 1'b0;
    tick(); tick(); tick();
    checkOutput("reset_mreq", m_req, 0);
    checkOutput("reset_mwe", m_we, 0);
    checkOutput("reset_maddr", m_addr, 0);
    checkOutput("reset_mwdata", m_wdata, 0);
    checkOutput("reset_istat", i_status, S_IDLE);
    checkOutput("reset_dstat", d_status, S_IDLE);
    checkOutput("reset_irdata", i_rdata, 0);
    checkOutput("reset_drdata", d_rdata, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) applyStimulus(vecs[k], k);

    // Both requesters held continuously with single-cycle acks.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    nGrants = 0; cyc = 0; prevReq = 1'b0;
    while (nGrants < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (m_req && !prevReq) begin
        grantD[nGrants] = (m_addr == 32'h0000_0200);
        nGrants++;
      end
      prevReq = m_req;
      m_ack   = m_req;
      m_rdata = 32'(cyc);
    end
    m_ack = 1'b0;
    checkOutput("grant_count", 32'(nGrants), 10);
    starve = 0;
    for (int g = 0; g < 10; g++) begin
      expD = (starve < STARVE_LIMIT);
      if (expD) starve = (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
      else      starve = 0;
      if (g < nGrants) checkOutput($sformatf("grant%0d_isData", g), grantD[g], expD);
    end

    // Reset in the middle of a load, with a stray ack arriving afterwards.
    i_req = 1'b0; d_req = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
    tick();
    checkOutput("rstmid_busy_mreq", m_req, 1);
    checkOutput("rstmid_busy_dstat", d_status, S_PEND);
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("rstmid_mreq", m_req, 0);
    checkOutput("rstmid_maddr", m_addr, 0);
    checkOutput("rstmid_mwe", m_we, 0);
    checkOutput("rstmid_dstat", d_status, S_IDLE);
    checkOutput("rstmid_drdata", d_rdata, 0);
    m_ack = 1'b1; m_rdata = 32'hBADB_AD00;
    tick();
    m_ack = 1'b0;
    checkOutput("lateack_dstat", d_status, S_IDLE);
    checkOutput("lateack_drdata", d_rdata, 0);
    checkOutput("lateack_mreq", m_req, 0);
    tick();
    checkOutput("lateack_dstat2", d_status, S_IDLE);

    // Randomized traffic against the transaction-level model.
    starve = 0; mIR = '0; mDR = '0;
    pendI = 1'b0; pendD = 1'b0;
    iA = '0; dA = '0; dWd = '0; dW = 1'b0;
    for (int r = 0; r < 60; r++) begin
      if (!pendI && $urandom_range(0, 1) == 1) begin
        pendI = 1'b1; iA = $urandom;
      end
      if (!pendD && $urandom_range(0, 2) != 0) begin
        pendD = 1'b1; dA = $urandom; dWd = $urandom; dW = 1'($urandom_range(0, 1));
      end
      if (!pendI && !pendD) begin
        pendI = 1'b1; iA = $urandom;
      end
      winD = pendD && (!pendI || starve < STARVE_LIMIT);
      if (winD) begin
        if (pendI && starve < STARVE_LIMIT) starve++;
      end else begin
        starve = 0;
      end
      i_req = pendI; i_addr = iA;
      d_req = pendD; d_addr = dA; d_we = dW; d_wdata = dWd;
      tick();
      checkOutput("rnd_mreq", m_req, 1);
      checkOutput("rnd_maddr", m_addr, winD ? dA : iA);
      checkOutput("rnd_mwe", m_we, (winD && dW) ? 1 : 0);
      if (winD && dW) checkOutput("rnd_mwdata", m_wdata, dWd);
      checkOutput("rnd_other_grant", winD ? i_status : d_status,
                  (winD ? pendI : pendD) ? S_PEND : S_IDLE);
      timedOut = ($urandom_range(0, 11) == 0);
      delay    = timedOut ? -1 : int'($urandom_range(1, 5));
      rd       = $urandom;
      er       = ($urandom_range(0, 7) == 0);
      serveTxn(winD, delay, rd, er, (timedOut || er) ? S_ERR : S_DONE,
               winD ? pendI : pendD, "rnd");
      if (!timedOut) begin
        if (winD) begin
          if (!dW) mDR = rd;
        end else begin
          mIR = rd;
        end
      end
      checkOutput("rnd_irdata", i_rdata, mIR);
      checkOutput("rnd_drdata", d_rdata, mDR);
      if (winD) begin
        pendD = 1'b0; d_req = 1'b0;
      end else begin
        pendI = 1'b0; i_req = 1'b0;
      end
      tick();
      checkOutput("rnd_idle_mreq", m_req, 0);
      checkOutput("rnd_idle_istat", i_status, pendI ? S_PEND : S_IDLE);
      checkOutput("rnd_idle_dstat", d_status, pendD ? S_PEND : S_IDLE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
